multi_cycle_ctrl: RTL
=====================

// Module: multi_cycle_ctrl
// PURPOSE
// Main control FSM for the multi-cycle version of the MIPS datapath. Sequences fetch, decode, execute, memory and
// writeback over several clocks per instruction, replacing the single-cycle combinational control decoder.
// Stalls every memory access until the MIO bus returns MIO_ready, with a bounded wait.
// Sits between the IR opcode field and the datapath muxes, enables and ALU_ctrl.
// PARAMETERS
// WAIT_LIMIT  16  max consecutive MIO_ready-low cycles in one memory state; 0 disables the timeout
// CNT_W       5   width of wait counter; must satisfy 2**CNT_W > WAIT_LIMIT
// PORTS
// clk          in   1   rising-edge clock
// reset        in   1   asynchronous, active-high
// opcode       in   6   IR[31:26], valid from ID onward
// MIO_ready    in   1   memory/IO completes the current access this cycle
// PCWrite      out  1   unconditional PC load
// PCWriteCond  out  1   PC load if ALU zero (beq)
// IorD         out  1   0 = PC, 1 = ALU_out drives memory address
// MemRead      out  1   memory read request
// MemWrite     out  1   memory write strobe (mem_w)
// CPU_MIO      out  1   bus request: MemRead | MemWrite
// IRWrite      out  1   latch instruction register
// MemtoReg     out  1   register write data: 0 = ALU_out, 1 = MDR
// RegDst       out  1   destination register: 0 = rt, 1 = rd
// RegWrite     out  1   register file write enable
// ALUSrcA      out  1   0 = PC, 1 = rs
// ALUSrcB      out  2   00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
// ALUop        out  2   00 = add, 01 = sub, 10 = funct decode (same encoding as ALU_ctrl input)
// PCSource     out  2   00 = ALU result, 01 = ALU_out, 10 = jump address
// bus_err      out  1   one-cycle pulse on memory timeout
// state        out  4   current state, for debug/VGA display
// BEHAVIOUR
// - States: IF=0, ID=1, MA=2, MRD=3, MWB=4, MWR=5, EXR=6, RWB=7, BR=8, JMP=9, IEX=10, IWB=11.
//   Codes 12-15 are illegal and return to IF on the next clock.
// - Reset (asynchronous): state=IF, wait_cnt=0, bus_err=0.
//   While reset=1, PCWrite, PCWriteCond, IRWrite, RegWrite, MemWrite and MemRead are all forced to 0.
// - Outputs are combinational from state (and MIO_ready where stated). Any signal not listed for a state is 0.
// - IF: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=00.
//   IRWrite=PCWrite=1 only in the cycle MIO_ready=1; that cycle goes to ID, otherwise stay in IF.
// - ID: ALUSrcA=0, ALUSrcB=11, ALUop=00 (branch target into ALU_out).
//   Next state by opcode:
//   000000 -> EXR; 100011/101011 -> MA; 000100 -> BR; 000010 -> JMP; 001000 -> IEX; any other -> IF (executes as NOP).
// - MA: ALUSrcA=1, ALUSrcB=10, ALUop=00. lw -> MRD, sw -> MWR.
// - MRD: MemRead=1, IorD=1. Go to MWB on MIO_ready, else stay.
// - MWB: RegWrite=1, MemtoReg=1, RegDst=0 -> IF.
// - MWR: MemWrite=1, IorD=1, held while waiting. Go to IF on MIO_ready.
//   The bus samples the write on the MIO_ready cycle.
// - EXR: ALUSrcA=1, ALUSrcB=00, ALUop=10 -> RWB.
// - RWB: RegWrite=1, RegDst=1, MemtoReg=0 -> IF.
// - BR: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=01 -> IF.
// - JMP: PCWrite=1, PCSource=10 -> IF.
// - IEX: ALUSrcA=1, ALUSrcB=10, ALUop=00 -> IWB.
// - IWB: RegWrite=1, RegDst=0, MemtoReg=0 -> IF.
// - CPI: R-type/addi 4, lw 5, sw 4, beq 3, j 3, undefined opcode 2; each memory state adds its wait cycles.
// - Wait counter and timeout:
//   - wait_cnt increments each cycle in IF/MRD/MWR with MIO_ready=0, and clears on any state change.
//   - If WAIT_LIMIT!=0 and wait_cnt==WAIT_LIMIT-1 with MIO_ready=0: next clock go to IF, wait_cnt=0, bus_err=1 for
//     exactly one cycle. No IRWrite, PCWrite or RegWrite occurs for that access, so a fetch timeout retries the same PC.
//   - MIO_ready=1 on the limit cycle means the access completes normally and bus_err stays 0.
// - Reset asserted mid-instruction aborts it at once: no partial register or PC write; the FSM restarts in IF.
// TESTING
// - Reset, then MIO_ready=1 always, opcode=000000 -> state 0,1,6,7,0; RegWrite=1 only in state 7 with RegDst=1.
// - lw (100011), MIO_ready low 3 cycles in MRD -> MRD held 4 cycles, MemRead=1 throughout, then MWB with RegWrite=1, MemtoReg=1.
// - beq (000100) -> IF,ID,BR,IF; PCWriteCond=1, ALUop=01, PCSource=01 only in BR. j (000010) -> PCWrite=1, PCSource=10 in JMP.
// - WAIT_LIMIT=4, MIO_ready=0 in IF -> after 4 cycles bus_err pulses 1 cycle, state stays 0, PCWrite/IRWrite never 1.
// - Opcode 111111 -> IF,ID,IF, with no RegWrite/MemWrite/PCWriteCond during the sequence.
// - Assert reset while in MWR with MIO_ready=0 -> MemWrite drops same cycle; after release state=0, wait_cnt=0.

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS main control FSM: sequences IF/ID/EX/MEM/WB per instruction and
// stalls memory states on MIO_ready with an optional bounded wait that raises bus_err.
module multi_cycle_ctrl #(
  parameter int unsigned WAIT_LIMIT = 16,
  parameter int unsigned CNT_W      = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       MIO_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       CPU_MIO,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUop,
  output logic [1:0] PCSource,
  output logic       bus_err,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IF  = 4'd0,  S_ID  = 4'd1,  S_MA  = 4'd2,  S_MRD = 4'd3,
    S_MWB = 4'd4,  S_MWR = 4'd5,  S_EXR = 4'd6,  S_RWB = 4'd7,
    S_BR  = 4'd8,  S_JMP = 4'd9,  S_IEX = 4'd10, S_IWB = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam bit               TIMEOUT_EN = (WAIT_LIMIT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WAIT_LIMIT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             bus_err_q, bus_err_d;
  logic             mem_wait;
  logic             timeout;

  // A memory state is stalled whenever the bus has not completed this cycle.
  assign mem_wait = ((state_q == S_IF) || (state_q == S_MRD) || (state_q == S_MWR)) && !MIO_ready;
  assign timeout  = TIMEOUT_EN && mem_wait && (wait_cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IF;
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      bus_err_q  <= bus_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    bus_err_d  = 1'b0;
    if (timeout) begin
      // Abandon the access without any architectural write; a fetch retries the same PC.
      state_d   = S_IF;
      bus_err_d = 1'b1;
    end else begin
      if (mem_wait) wait_cnt_d = wait_cnt_q + CNT_W'(1);
      case (state_q)
        S_IF:  if (MIO_ready) state_d = S_ID;
        S_ID: begin
          case (opcode)
            OP_RTYPE:    state_d = S_EXR;
            OP_LW, OP_SW: state_d = S_MA;
            OP_BEQ:      state_d = S_BR;
            OP_J:        state_d = S_JMP;
            OP_ADDI:     state_d = S_IEX;
            default:     state_d = S_IF;
          endcase
        end
        S_MA: begin
          if (opcode == OP_LW)      state_d = S_MRD;
          else if (opcode == OP_SW) state_d = S_MWR;
          else                      state_d = S_IF;
        end
        S_MRD: if (MIO_ready) state_d = S_MWB;
        S_MWB: state_d = S_IF;
        S_MWR: if (MIO_ready) state_d = S_IF;
        S_EXR: state_d = S_RWB;
        S_RWB: state_d = S_IF;
        S_BR:  state_d = S_IF;
        S_JMP: state_d = S_IF;
        S_IEX: state_d = S_IWB;
        S_IWB: state_d = S_IF;
        default: state_d = S_IF;
      endcase
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUop       = 2'b00;
    PCSource    = 2'b00;
    case (state_q)
      S_IF: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MIO_ready;
        PCWrite = MIO_ready;
      end
      S_ID:  ALUSrcB = 2'b11;
      S_MA: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXR: begin
        ALUSrcA = 1'b1;
        ALUop   = 2'b10;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BR: begin
        ALUSrcA     = 1'b1;
        ALUop       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_IEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_IWB: RegWrite = 1'b1;
      default: ;
    endcase
    // No write or bus strobe may escape while reset is held.
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      MemWrite    = 1'b0;
      MemRead     = 1'b0;
    end
    CPU_MIO = MemRead | MemWrite;
  end

  assign bus_err = bus_err_q;
  assign state   = state_q;

endmodule
